// File: rtl/mac_saturado_pipe.sv
// ---------------------------------------------------------------------------
// mac_saturado_pipe
//
// Pipelined signed fixed-point multiply-add with saturation:
//    resultado = sat(trunc(dato1*dato2 + addend))
// Data is Q(N-FRAC).FRAC two's complement on every data port.
//
// Pipeline:
//    S1  input capture (dato1..3, modo, clr_acc, in_valid)
//    S2  exact 2N-bit signed product, sideband carried along
//    S3  addend select, add, floor shift, saturate -> output registers
//
// Ports:
//    clk        single clock, rising edge
//    reset      asynchronous, active-low
//    in_valid   sample strobe; inputs captured when high
//    dato1      multiplicand (N bits, signed)
//    dato2      multiplier   (N bits, signed)
//    dato3      external addend, used when modo=0
//    modo       0: add dato3, 1: add internal accumulator
//    clr_acc    with modo=1, the addend is forced to zero for this sample
//    out_valid  resultado/ovf carry a new result this cycle
//    resultado  saturated, truncated result (N bits, signed)
//    ovf        saturation occurred on this result
// ---------------------------------------------------------------------------
module mac_saturado_pipe #(
   parameter int N    = 16,
   parameter int FRAC = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   input  logic [N-1:0] dato1,
   input  logic [N-1:0] dato2,
   input  logic [N-1:0] dato3,
   input  logic         modo,
   input  logic         clr_acc,
   output logic         out_valid,
   output logic [N-1:0] resultado,
   output logic         ovf
);

   // Saturation limits expressed in the 2N+1 bit width of the shifted sum
   localparam logic signed [2*N:0] MAX_T = {{(N+2){1'b0}}, {(N-1){1'b1}}};
   localparam logic signed [2*N:0] MIN_T = {{(N+2){1'b1}}, {(N-1){1'b0}}};
   localparam logic [N-1:0] MAX_RES = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] MIN_RES = {1'b1, {(N-1){1'b0}}};

   // S1 registers
   logic         v1;
   logic [N-1:0] d1_s1;
   logic [N-1:0] d2_s1;
   logic [N-1:0] d3_s1;
   logic         modo_s1;
   logic         clr_s1;

   // S2 registers
   logic                  v2;
   logic signed [2*N-1:0] prod_s2;
   logic [N-1:0]          d3_s2;
   logic                  modo_s2;
   logic                  clr_s2;

   // Accumulator holds the last saturated accumulate-mode result
   logic [N-1:0] acc;

   // S2 / S3 combinational nets
   logic signed [2*N-1:0] d1_ext;
   logic signed [2*N-1:0] d2_ext;
   logic [N-1:0]          addend;
   logic signed [2*N:0]   addend_ext;
   logic signed [2*N:0]   addend_sh;
   logic signed [2*N:0]   prod_ext;
   logic signed [2*N:0]   sum;
   logic signed [2*N:0]   t;
   logic [N-1:0]          sat_res;
   logic                  sat_ovf;

   // S1: plain capture every cycle; contents only matter when v1 is set
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v1      <= 1'b0;
         d1_s1   <= '0;
         d2_s1   <= '0;
         d3_s1   <= '0;
         modo_s1 <= 1'b0;
         clr_s1  <= 1'b0;
      end else begin
         v1      <= in_valid;
         d1_s1   <= dato1;
         d2_s1   <= dato2;
         d3_s1   <= dato3;
         modo_s1 <= modo;
         clr_s1  <= clr_acc;
      end
   end

   // Operands are sign-extended to 2N bits so the product is exact
   assign d1_ext = {{N{d1_s1[N-1]}}, d1_s1};
   assign d2_ext = {{N{d2_s1[N-1]}}, d2_s1};

   // S2: multiply and forward the sideband of the same sample
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v2      <= 1'b0;
         prod_s2 <= '0;
         d3_s2   <= '0;
         modo_s2 <= 1'b0;
         clr_s2  <= 1'b0;
      end else begin
         v2      <= v1;
         prod_s2 <= d1_ext * d2_ext;
         d3_s2   <= d3_s1;
         modo_s2 <= modo_s1;
         clr_s2  <= clr_s1;
      end
   end

   // S3 arithmetic. The addend is an integer-aligned Q value, so it is
   // shifted up by FRAC to line up with the 2*FRAC fraction bits of the
   // product. 2N+1 bits cannot wrap for any operand combination.
   assign addend     = modo_s2 ? (clr_s2 ? '0 : acc) : d3_s2;
   assign addend_ext = {{(N+1){addend[N-1]}}, addend};
   assign addend_sh  = addend_ext <<< FRAC;
   assign prod_ext   = {prod_s2[2*N-1], prod_s2};
   assign sum        = prod_ext + addend_sh;
   assign t          = sum >>> FRAC;

   // Clamp the floored value into the N-bit signed range
   always_comb begin
      sat_res = t[N-1:0];
      sat_ovf = 1'b0;
      if (t > MAX_T) begin
         sat_res = MAX_RES;
         sat_ovf = 1'b1;
      end else if (t < MIN_T) begin
         sat_res = MIN_RES;
         sat_ovf = 1'b1;
      end
   end

   // Output stage; the accumulator is written in the same edge as the
   // result, so a following accumulate sample in S2 sees it without a bubble
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         resultado <= '0;
         ovf       <= 1'b0;
         acc       <= '0;
      end else begin
         out_valid <= v2;
         if (v2) begin
            resultado <= sat_res;
            ovf       <= sat_ovf;
            if (modo_s2) begin
               acc <= sat_res;
            end
         end
      end
   end

endmodule
